// File: rtl/picorv32_regfile_multi.sv
// picorv32_regfile_multi
//   Parametrised register file with NRD synchronous read ports (registered,
//   1-cycle latency) and one write port. After reset, an init sequencer
//   writes zero to every entry, so the storage itself needs no reset flops.
//
// Parameters: XLEN (data width), NREGS (entries), ADDR_W (address width),
//             NRD (read ports, 1..4), ZERO_REG (1 = entry 0 reads as zero
//             and ignores writes).
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
//   data to reads of the same address (write-first). When it is undefined,
//   such reads return the old contents (read-first).
//
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   busy    high while the init sequencer owns the array
//   wen     write enable;  waddr / wdata write address and data
//   ren     per-port read enable
//   raddr   read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata   read data,      port p at [p*XLEN +: XLEN]
//   rvalid  per-port: rdata for that port was updated this cycle
module picorv32_regfile_multi #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   busy,
  input  logic                   wen,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [XLEN-1:0]        wdata,
  input  logic [NRD-1:0]         ren,
  input  logic [NRD*ADDR_W-1:0]  raddr,
  output logic [NRD*XLEN-1:0]    rdata,
  output logic [NRD-1:0]         rvalid
);

  // Counter is one bit wider than the address so NREGS == 2**ADDR_W fits.
  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(NREGS - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   cnt, cnt_nx;
  logic              init_we;
  logic              wr_ok;
  logic [NRD-1:0]    rd_en;
  logic [ADDR_W-1:0] ra;
  logic [XLEN-1:0]   rd_val [NRD];
  logic [XLEN-1:0]   mem    [NREGS];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    init_we  = 1'b0;
    case (state)
      S_INIT: begin
        init_we = 1'b1;
        cnt_nx  = cnt + 1'b1;
        if (cnt == LAST_C) state_nx = S_READY;
      end
      S_READY: ;
      default: state_nx = S_INIT;
    endcase
  end

  assign busy = (state == S_INIT);

  // ---------------------------------------------------------- write port
  assign wr_ok = wen && !busy
              && ({1'b0, waddr} < NREGS_C)
              && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (resetn && init_we)
      mem[cnt[ADDR_W-1:0]] <= '0;
    else if (resetn && wr_ok)
      mem[waddr] <= wdata;
  end

  // ---------------------------------------------------------- read ports
  assign rd_en = ren & {NRD{~busy}};

  always_comb begin
    ra = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra        = raddr[p*ADDR_W +: ADDR_W];
      rd_val[p] = '0;
      if (({1'b0, ra} < NREGS_C) && !((ZERO_REG != 0) && (ra == '0))) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (waddr == ra)) rd_val[p] = wdata;
        else                        rd_val[p] = mem[ra];
`else
        rd_val[p] = mem[ra];
`endif
      end
    end
  end

  // rdata holds its last value when a port is not read; it is only
  // cleared by reset, so it reads zero throughout init.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= rd_en;
      for (int unsigned p = 0; p < NRD; p++)
        if (rd_en[p]) rdata[p*XLEN +: XLEN] <= rd_val[p];
    end
  end

endmodule

// File: tb/tb_picorv32_regfile_multi.sv
// Testbench for picorv32_regfile_multi. Three instances share one stimulus:
//   u_a : NREGS=32, ZERO_REG=1
//   u_b : NREGS=32, ZERO_REG=0
//   u_c : NREGS=24, ZERO_REG=1
// A behavioural model per instance predicts busy/rvalid/rdata each cycle;
// directed literal checks pin key values.
module tb_picorv32_regfile_multi;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  ren = '0;
  logic [9:0]  raddr = '0;

  logic        busy_a, busy_b, busy_c;
  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  rv_a, rv_b, rv_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picorv32_regfile_multi #(.XLEN(32), .NREGS(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .resetn(resetn), .busy(busy_a), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rd_a), .rvalid(rv_a));
  picorv32_regfile_multi #(.XLEN(32), .NREGS(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0)) u_b (
    .clk(clk), .resetn(resetn), .busy(busy_b), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rd_b), .rvalid(rv_b));
  picorv32_regfile_multi #(.XLEN(32), .NREGS(24), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) u_c (
    .clk(clk), .resetn(resetn), .busy(busy_c), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rd_c), .rvalid(rv_c));

  // ------------------------------------------------------------ model
  int          nregs_of [3] = '{32, 32, 24};
  bit          zr_of    [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mm  [3][32];
  int          cyc [3];
  bit          eb  [3];
  logic [31:0] erd [3][2];
  bit          erv [3][2];
  bit          started = 1'b0;

  function automatic bit write_ok(int i);
    return wen && (int'(waddr) < nregs_of[i]) && !(zr_of[i] && waddr == 5'd0);
  endfunction

  function automatic logic [31:0] read_val(int i, logic [4:0] a);
    if (int'(a) >= nregs_of[i]) return 32'h0;
    if (zr_of[i] && a == 5'd0) return 32'h0;
    if (BYP && write_ok(i) && waddr == a) return wdata;
    return mm[i][a];
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!resetn) begin
        cyc[i] = 0;
        eb[i]  = 1'b1;
        for (int p = 0; p < 2; p++) begin erd[i][p] = 32'h0; erv[i][p] = 1'b0; end
      end else if (eb[i]) begin
        cyc[i]++;
        for (int p = 0; p < 2; p++) erv[i][p] = 1'b0;
        if (cyc[i] == nregs_of[i]) begin
          eb[i] = 1'b0;
          for (int k = 0; k < 32; k++) mm[i][k] = 32'h0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          erv[i][p] = ren[p];
          if (ren[p]) erd[i][p] = read_val(i, raddr[p*5 +: 5]);
        end
        if (write_ok(i)) mm[i][waddr] = wdata;
      end
    end
  end

  // ---------------------------------------------------------- checking
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int i, logic b, logic [1:0] rv, logic [63:0] rd);
    chk($sformatf("busy[u%0d]", i), {63'b0, b}, {63'b0, eb[i]});
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rvalid[u%0d][%0d]", i, p), {63'b0, rv[p]}, {63'b0, erv[i][p]});
      chk($sformatf("rdata[u%0d][%0d]", i, p), {32'b0, rd[p*32 +: 32]}, {32'b0, erd[i][p]});
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, busy_a, rv_a, rd_a);
      cmp(1, busy_b, rv_b, rd_b);
      cmp(2, busy_c, rv_c, rd_c);
    end
  end

  // ---------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d; ren = 2'b00;
    step();
    wen = 1'b0;
  endtask

  task automatic rd2(logic [4:0] a0, logic [4:0] a1);
    ren = 2'b11; raddr = {a1, a0};
    step();
    ren = 2'b00;
  endtask

  // Counts busy cycles starting from cycle 0 (the current cycle).
  task automatic count_busy(output int na, output int nc, input bit poke);
    na = 0; nc = 0;
    for (int k = 0; k < 40; k++) begin
      if (poke && k == 20) begin wen = 1'b0; ren = 2'b00; end
      if (poke && k == 5) chk("rvalid_during_busy", {62'b0, rv_a}, 64'd0);
      if (busy_a) na++;
      if (busy_c) nc++;
      step();
    end
  endtask

  initial begin
    int na, nc;
    repeat (3) step();
    resetn = 1'b1;
    chk("reset_rdata", rd_a, 64'h0);
    count_busy(na, nc, 1'b0);
    chk("busy_len_32", 64'(na), 64'd32);
    chk("busy_len_24", 64'(nc), 64'd24);

    // every entry reads zero after init
    for (int a = 0; a < 32; a++) rd2(5'(a), 5'(a));
    step();

    // write / read / hold
    wr(5'd5, 32'hDEADBEEF);
    ren = 2'b01; raddr = {5'd0, 5'd5};
    step();
    chk("rd5_data", {32'b0, rd_a[31:0]}, 64'hDEADBEEF);
    chk("rd5_valid", {63'b0, rv_a[0]}, 64'd1);
    ren = 2'b00;
    step();
    chk("rd5_valid_drop", {63'b0, rv_a[0]}, 64'd0);
    chk("rd5_hold", {32'b0, rd_a[31:0]}, 64'hDEADBEEF);

    // zero register
    wr(5'd0, 32'h12345678);
    rd2(5'd0, 5'd0);
    chk("zr1_entry0", {32'b0, rd_a[31:0]}, 64'h0);
    chk("zr0_entry0", {32'b0, rd_b[31:0]}, 64'h12345678);

    // collision
    wr(5'd7, 32'h11);
    wen = 1'b1; waddr = 5'd7; wdata = 32'h22; ren = 2'b11; raddr = {5'd7, 5'd7};
    step();
    wen = 1'b0;
    chk("collide_p0", {32'b0, rd_a[31:0]},  BYP ? 64'h22 : 64'h11);
    chk("collide_p1", {32'b0, rd_a[63:32]}, BYP ? 64'h22 : 64'h11);
    rd2(5'd7, 5'd7);
    chk("after_collide", rd_a, 64'h00000022_00000022);

    // out of range on the 24-entry instance
    wr(5'd30, 32'hA5A5A5A5);
    rd2(5'd30, 5'd23);
    chk("oor_c", {32'b0, rd_c[31:0]}, 64'h0);
    chk("inrange_a30", {32'b0, rd_a[31:0]}, 64'hA5A5A5A5);

    // assorted writes, then read back through both ports
    for (int a = 1; a < 32; a += 3) wr(5'(a), 32'h1000_0000 + 32'(a * 257));
    wr(5'd3, 32'hCAFEF00D);
    for (int a = 0; a < 32; a += 2) rd2(5'(a), 5'(31 - a));
    step();

    // reset mid-use, then mid-init at cycle 10
    resetn = 1'b0; step(); resetn = 1'b1;
    repeat (10) step();
    resetn = 1'b0; step(); resetn = 1'b1;
    wen = 1'b1; waddr = 5'd3; wdata = 32'hBAD0BAD0; ren = 2'b11; raddr = {5'd3, 5'd3};
    count_busy(na, nc, 1'b1);
    chk("rebusy_len_32", 64'(na), 64'd32);
    chk("rebusy_len_24", 64'(nc), 64'd24);
    rd2(5'd5, 5'd3);
    chk("cleared_5_3", rd_a, 64'h0);
    rd2(5'd7, 5'd30);
    chk("cleared_7_30", rd_a, 64'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
